// File: rtl/qspi_pkg.sv
// qspi_pkg: constants and types shared by the QSPI responder (qspi_target)
// and the benches that drive it.
//   QSPI_CMD_QREAD / QSPI_CMD_QWRITE : recognised command bytes
//   QSPI_ADDR_NIBBLES                : nibbles in the address phase (24 bits)
//   qspi_state_e                     : responder protocol state
//   qspi_cmd_known()                 : true for a command the responder serves
package qspi_pkg;

    localparam logic [7:0] QSPI_CMD_QREAD    = 8'hEB;
    localparam logic [7:0] QSPI_CMD_QWRITE   = 8'h38;
    localparam int         QSPI_ADDR_NIBBLES = 6;

    typedef enum logic [2:0] {
        QSPI_IDLE   = 3'd0,
        QSPI_CMD    = 3'd1,
        QSPI_ADDR   = 3'd2,
        QSPI_DUMMY  = 3'd3,
        QSPI_RDATA  = 3'd4,
        QSPI_WDATA  = 3'd5,
        QSPI_IGNORE = 3'd6
    } qspi_state_e;

    function automatic logic qspi_cmd_known(input logic [7:0] cmd);
        return (cmd == QSPI_CMD_QREAD) || (cmd == QSPI_CMD_QWRITE);
    endfunction

endpackage

// File: rtl/qspi_edge_sync.sv
// qspi_edge_sync: two-flop synchronizer plus edge detect for a group of
// asynchronous single-bit pins.
//   clk_i   : sampling clock
//   async_i : asynchronous pin group
//   rise_o  : one-cycle pulse per bit, synced level went 0 -> 1
//   fall_o  : one-cycle pulse per bit, synced level went 1 -> 0
// Pulses appear 2 clk after the pin edge.
module qspi_edge_sync #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;
    logic [W-1:0] hist_q;

    // No reset on purpose: the history keeps tracking the pins through a
    // reset, so a chip select that is still low afterwards is not mistaken
    // for a fresh select edge. The master has to re-assert it.
    always_ff @(posedge clk_i) begin
        s1_q   <= async_i;
        s2_q   <= s1_q;
        hist_q <= s2_q;
    end

    assign rise_o = s2_q & ~hist_q;
    assign fall_o = ~s2_q & hist_q;

endmodule

// File: rtl/qspi_target.sv
// qspi_target: quad-SPI responder turning 0xEB quad reads and 0x38 quad
// writes into byte accesses on a synchronous memory port. SPI pins are
// oversampled in the clk domain.
//   clk, reset            : system clock, synchronous active-high reset
//   spi_cs_n, spi_sck     : chip select (active low), SPI mode-0 clock
//   spi_din / spi_dout    : IO[3:0] input and output paths
//   spi_oe                : IO[3:0] output enable (all bits equal)
//   mem_addr              : byte address
//   mem_rd / mem_rdata    : one-cycle read strobe, data valid next cycle
//   mem_wr / mem_wdata    : one-cycle write strobe with address and data
//   dbg_state_o           : current protocol state, for observation
// Memory port: each strobe is a single-cycle request that is always
// accepted; a read returns mem_rdata on the cycle after mem_rd.
module qspi_target
    import qspi_pkg::*;
#(
    parameter int PA    = 24,
    parameter int DUMMY = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          spi_cs_n,
    input  logic          spi_sck,
    input  logic [3:0]    spi_din,
    output logic [3:0]    spi_dout,
    output logic [3:0]    spi_oe,
    output logic [PA-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_rdata,
    output logic          mem_wr,
    output logic [7:0]    mem_wdata,
    output qspi_state_e   dbg_state_o
);

    // Pin synchronization
    logic cs_deassert, cs_assert, sck_rise, sck_fall;
    logic [3:0] din_s1_q, din_s2_q;

    qspi_edge_sync #(.W(2)) u_sync (
        .clk_i   (clk),
        .async_i ({spi_cs_n, spi_sck}),
        .rise_o  ({cs_deassert, sck_rise}),
        .fall_o  ({cs_assert, sck_fall})
    );

    // Data goes through the same two-flop depth as SCK so that din_s2_q is
    // aligned with the detected rise.
    always_ff @(posedge clk) begin
        din_s1_q <= spi_din;
        din_s2_q <= din_s1_q;
    end

    // State
    qspi_state_e   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;          // nibble / dummy-cycle counter
    logic [3:0]    cmd_hi_q, cmd_hi_d;    // first command nibble
    logic          is_read_q, is_read_d;
    logic [19:0]   addr_sh_q, addr_sh_d;  // first five address nibbles
    logic [PA-1:0] mem_addr_q, mem_addr_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic [3:0]    wnib_q, wnib_d;        // high nibble of the write byte
    logic [7:0]    pf_q, pf_d;            // byte fetched for the next hi drive
    logic [3:0]    lo_q, lo_d;            // low nibble still to be driven
    logic          hi_q, hi_d;            // next data nibble is the high one
    logic          rd_pend_q, rd_pend_d;  // mem_rdata valid this cycle
    logic [3:0]    dout_q, dout_d;
    logic          oe_q, oe_d;

    logic [7:0]    cmd_full;
    logic [23:0]   addr_full;

    assign cmd_full  = {cmd_hi_q, din_s2_q};
    assign addr_full = {addr_sh_q, din_s2_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_hi_d    = cmd_hi_q;
        is_read_d   = is_read_q;
        addr_sh_d   = addr_sh_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        wnib_d      = wnib_q;
        pf_d        = pf_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        rd_pend_d   = mem_rd_q;
        dout_d      = dout_q;
        oe_d        = oe_q;

        if (rd_pend_q) begin
            pf_d = mem_rdata;
        end
        // Writes use the current address on the strobe cycle, then advance.
        if (mem_wr_q) begin
            mem_addr_d = mem_addr_q + 1'b1;
        end

        unique case (state_q)
            QSPI_IDLE: begin
                oe_d = 1'b0;
                if (cs_assert) begin
                    state_d = QSPI_CMD;
                    cnt_d   = 4'd0;
                end
            end
            QSPI_CMD: begin
                if (sck_rise) begin
                    cmd_hi_d = din_s2_q;
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q == 4'd1) begin
                        cnt_d     = 4'd0;
                        is_read_d = (cmd_full == QSPI_CMD_QREAD);
                        state_d   = qspi_cmd_known(cmd_full) ? QSPI_ADDR : QSPI_IGNORE;
                    end
                end
            end
            QSPI_ADDR: begin
                if (sck_rise) begin
                    addr_sh_d = addr_full[19:0];
                    cnt_d     = cnt_q + 4'd1;
                    if (cnt_q == 4'(QSPI_ADDR_NIBBLES - 1)) begin
                        cnt_d      = 4'd0;
                        hi_d       = 1'b1;
                        mem_addr_d = addr_full[PA-1:0];
                        if (is_read_q) begin
                            state_d  = QSPI_DUMMY;
                            mem_rd_d = 1'b1;   // first byte fetched during dummy
                        end else begin
                            state_d  = QSPI_WDATA;
                        end
                    end
                end
            end
            QSPI_DUMMY: begin
                if (sck_rise) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(DUMMY - 1)) begin
                        state_d = QSPI_RDATA;
                    end
                end
            end
            QSPI_RDATA: begin
                if (sck_fall) begin
                    oe_d = 1'b1;
                    if (hi_q) begin
                        // Keep the low half locally so the prefetch can
                        // overwrite pf_q while it is still owed.
                        dout_d     = pf_q[7:4];
                        lo_d       = pf_q[3:0];
                        hi_d       = 1'b0;
                        mem_addr_d = mem_addr_q + 1'b1;
                        mem_rd_d   = 1'b1;
                    end else begin
                        dout_d = lo_q;
                        hi_d   = 1'b1;
                    end
                end
            end
            QSPI_WDATA: begin
                if (sck_rise) begin
                    if (hi_q) begin
                        wnib_d = din_s2_q;
                        hi_d   = 1'b0;
                    end else begin
                        mem_wdata_d = {wnib_q, din_s2_q};
                        mem_wr_d    = 1'b1;
                        hi_d        = 1'b1;
                    end
                end
            end
            QSPI_IGNORE: begin
                oe_d = 1'b0;
            end
            default: begin
                state_d = QSPI_IDLE;
            end
        endcase

        // Deselect wins over everything: drop strobes, a half-written byte
        // and any prefetch still on its way back.
        if (cs_deassert) begin
            state_d   = QSPI_IDLE;
            oe_d      = 1'b0;
            dout_d    = 4'd0;
            mem_rd_d  = 1'b0;
            mem_wr_d  = 1'b0;
            rd_pend_d = 1'b0;
            hi_d      = 1'b1;
            cnt_d     = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= QSPI_IDLE;
            cnt_q       <= 4'd0;
            cmd_hi_q    <= 4'd0;
            is_read_q   <= 1'b0;
            addr_sh_q   <= 20'd0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= 8'd0;
            wnib_q      <= 4'd0;
            pf_q        <= 8'd0;
            lo_q        <= 4'd0;
            hi_q        <= 1'b1;
            rd_pend_q   <= 1'b0;
            dout_q      <= 4'd0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_hi_q    <= cmd_hi_d;
            is_read_q   <= is_read_d;
            addr_sh_q   <= addr_sh_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            wnib_q      <= wnib_d;
            pf_q        <= pf_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            rd_pend_q   <= rd_pend_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
        end
    end

    assign spi_dout    = dout_q;
    assign spi_oe      = {4{oe_q}};
    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_wdata   = mem_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_qspi_target.sv
// tb_qspi_target: directed bench for qspi_target. A QSPI master is driven
// from tasks; a byte memory answers the memory port; expected strobes and
// read nibbles come from a transaction-level model of the link.
module tb_qspi_target;
    import qspi_pkg::*;

    localparam int PA       = 24;
    localparam int DUMMY    = 4;
    localparam int SCK_HALF = 5;   // clk cycles per SCK phase

    // Clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          spi_cs_n = 1'b1;
    logic          spi_sck  = 1'b0;
    logic [3:0]    spi_din  = 4'd0;
    logic [3:0]    spi_dout;
    logic [3:0]    spi_oe;
    logic [PA-1:0] mem_addr;
    logic          mem_rd;
    logic [7:0]    mem_rdata = 8'd0;
    logic          mem_wr;
    logic [7:0]    mem_wdata;
    qspi_state_e   dbg_state;

    qspi_target #(.PA(PA), .DUMMY(DUMMY)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_cs_n    (spi_cs_n),
        .spi_sck     (spi_sck),
        .spi_din     (spi_din),
        .spi_dout    (spi_dout),
        .spi_oe      (spi_oe),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .dbg_state_o (dbg_state)
    );

    // Scoreboard state
    int n_checks = 0;
    int n_pass   = 0;
    logic [23:0] exp_rd_q[$];
    logic [31:0] exp_wr_q[$];
    logic [3:0]  exp_nib_q[$];
    logic [3:0]  got_q[$];
    logic [23:0] seen_rd_q[$];
    logic [3:0]  samp_dout;
    logic [3:0]  samp_oe;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // Memory model
    logic [7:0] mem [logic [23:0]];

    function automatic logic [7:0] mem_val(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_val(mem_addr);
        if (mem_wr) mem[mem_addr] = mem_wdata;
    end

    // Compare process: every strobe cycle is checked against the model.
    always @(negedge clk) begin
        if (mem_rd || mem_wr)
            check("strobe_exclusive", 32'(mem_rd & mem_wr), 32'd0);
        if (mem_rd) begin
            seen_rd_q.push_back(mem_addr);
            if (exp_rd_q.size() == 0) check("rd_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
            else check("rd_addr", 32'(mem_addr), 32'(exp_rd_q.pop_front()));
        end
        if (mem_wr) begin
            if (exp_wr_q.size() == 0) check("wr_unexpected", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
            else check("wr_addr_data", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
        end
    end

    // Driver tasks (SPI mode 0: master changes data while SCK low, target
    // drives on falls, both sample on rises)
    task automatic sck_rise(input logic [3:0] nib);
        spi_din = nib;
        repeat (SCK_HALF) @(negedge clk);
        samp_dout = spi_dout;
        samp_oe   = spi_oe;
        spi_sck   = 1'b1;
        repeat (SCK_HALF) @(negedge clk);
    endtask

    task automatic end_cs();
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_din  = 4'd0;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        logic [31:0] w;
        w = {cmd, a};
        spi_cs_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sck_rise(w[31-4*i -: 4]);
            check("oe_header", 32'(samp_oe), 32'h0);
            spi_sck = 1'b0;
        end
    endtask

    task automatic do_dummy();
        for (int d = 0; d < DUMMY; d++) begin
            sck_rise(4'h0);
            check("oe_dummy_low", 32'(samp_oe), 32'h0);
            check("oe_dummy_high", 32'(spi_oe), 32'h0);
            spi_sck = 1'b0;
        end
    endtask

    // Read of nbytes: addresses a..a+nbytes-1 streamed, plus one prefetch.
    task automatic do_read(input logic [23:0] a, input int nbytes);
        logic [7:0] b;
        for (int i = 0; i <= nbytes; i++) exp_rd_q.push_back(a + 24'(i));
        for (int i = 0; i < nbytes; i++) begin
            b = mem_val(a + 24'(i));
            exp_nib_q.push_back(b[7:4]);
            exp_nib_q.push_back(b[3:0]);
        end
        got_q.delete();
        seen_rd_q.delete();
        send_hdr(QSPI_CMD_QREAD, a);
        do_dummy();
        for (int n = 0; n < 2*nbytes; n++) begin
            sck_rise(4'h0);
            check("oe_data", 32'(samp_oe), 32'hF);
            check("dout", 32'(samp_dout), 32'(exp_nib_q.pop_front()));
            got_q.push_back(samp_dout);
            if (n != 2*nbytes - 1) spi_sck = 1'b0;
        end
        end_cs();
        check("rd_all_seen", 32'(exp_rd_q.size()), 32'd0);
        check("state_idle_after_rd", 32'(dbg_state), 32'(QSPI_IDLE));
    endtask

    // Write of nnib nibbles taken MSB-first from data; only full bytes land.
    task automatic do_write(input logic [23:0] a, input logic [31:0] data, input int nnib);
        for (int i = 0; i < nnib/2; i++)
            exp_wr_q.push_back({a + 24'(i), data[31-8*i -: 8]});
        send_hdr(QSPI_CMD_QWRITE, a);
        for (int i = 0; i < nnib; i++) begin
            sck_rise(data[31-4*i -: 4]);
            check("oe_write", 32'(samp_oe), 32'h0);
            spi_sck = 1'b0;
        end
        end_cs();
        check("wr_all_seen", 32'(exp_wr_q.size()), 32'd0);
    endtask

    initial begin
        mem[24'h000010] = 8'hA5;
        mem[24'h000011] = 8'h3C;
        mem[24'h000012] = 8'h00;
        mem[24'h000013] = 8'hFF;
        mem[24'hFFFFFF] = 8'h9B;
        mem[24'h000000] = 8'h4E;
        mem[24'h000030] = 8'hC7;

        // Reset values
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_oe", 32'(spi_oe), 32'h0);
        check("rst_dout", 32'(spi_dout), 32'h0);
        check("rst_mem_rd", 32'(mem_rd), 32'h0);
        check("rst_mem_wr", 32'(mem_wr), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(QSPI_IDLE));
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Quad read of four bytes at 0x10
        do_read(24'h000010, 4);
        check("rd1_byte0", 32'({got_q[0], got_q[1]}), 32'hA5);
        check("rd1_byte1", 32'({got_q[2], got_q[3]}), 32'h3C);
        check("rd1_byte2", 32'({got_q[4], got_q[5]}), 32'h00);
        check("rd1_byte3", 32'({got_q[6], got_q[7]}), 32'hFF);
        check("rd1_nreads", 32'(seen_rd_q.size()), 32'd5);
        check("rd1_prefetch_addr", 32'(seen_rd_q[4]), 32'h14);

        // Quad write of four bytes at 0x800004
        do_write(24'h800004, 32'h1234_5678, 8);
        check("wr_mem4", 32'(mem_val(24'h800004)), 32'h12);
        check("wr_mem5", 32'(mem_val(24'h800005)), 32'h34);
        check("wr_mem6", 32'(mem_val(24'h800006)), 32'h56);
        check("wr_mem7", 32'(mem_val(24'h800007)), 32'h78);

        // Three nibbles then deselect: only the first byte is written
        do_write(24'h000100, 32'hABCD_0000, 3);
        check("partial_first", 32'(mem_val(24'h000100)), 32'hAB);
        check("partial_none", 32'(mem.exists(24'h000101)), 32'd0);

        // Address wrap at the top of the space
        do_read(24'hFFFFFF, 2);
        check("wrap_byte0", 32'({got_q[0], got_q[1]}), 32'h9B);
        check("wrap_byte1", 32'({got_q[2], got_q[3]}), 32'h4E);
        check("wrap_second_addr", 32'(seen_rd_q[1]), 32'h000000);

        // Reset in the middle of read data
        exp_rd_q.push_back(24'h000030);
        exp_rd_q.push_back(24'h000031);
        send_hdr(QSPI_CMD_QREAD, 24'h000030);
        do_dummy();
        sck_rise(4'h0);
        check("rstmid_nib", 32'(samp_dout), 32'hC);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_oe", 32'(spi_oe), 32'h0);
        check("rstmid_state", 32'(dbg_state), 32'(QSPI_IDLE));
        check("rstmid_mem_rd", 32'(mem_rd), 32'h0);
        repeat (4) @(negedge clk);
        end_cs();
        check("rstmid_rd_seen", 32'(exp_rd_q.size()), 32'd0);
        check("rstmid_state_after", 32'(dbg_state), 32'(QSPI_IDLE));

        // Unknown command 0x9F followed by ten more SCK cycles
        spi_cs_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sck_rise((i == 0) ? 4'h9 : (i == 1) ? 4'hF : 4'(i));
            check("oe_ignore", 32'(samp_oe), 32'h0);
            spi_sck = 1'b0;
        end
        check("ignore_state", 32'(dbg_state), 32'(QSPI_IGNORE));
        end_cs();

        // Normal read afterwards
        do_read(24'h000010, 1);
        check("after_ignore_byte", 32'({got_q[0], got_q[1]}), 32'hA5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/qspi_target.md
# qspi_target

Quad-SPI responder: the memory-side end of the QSPI link the CPU's line-fill engine drives for icache/dcache misses. It decodes quad read (0xEB) and quad write (0x38) transactions and turns them into byte accesses on a simple synchronous memory port. It serves as the FPGA companion/test-chip memory model and as a synthesizable bench target. The SPI pins are oversampled in the single `clk` domain; there is no second clock.

## Interface
- `PA`, 24: address width in bits (address phase is always 24 bits; upper bits beyond `PA` ignored).
- `DUMMY`, 4: dummy SCK cycles between address and read data (legal 1..15).
- `clk`  in  1: system clock; all state on rising edge.
- `reset`  in  1: synchronous, active-high (decided: one clock, reset synchronous active-high).
- `spi_cs_n`  in  1: chip select, active low, asynchronous to `clk`.
- `spi_sck`  in  1: SPI clock, mode 0, asynchronous to `clk`.
- `spi_din`  in  4: IO[3:0] input path.
- `spi_dout`  out  4: IO[3:0] output path.
- `spi_oe`  out  4: IO[3:0] output enable, all bits equal.
- `mem_addr`  out  PA: byte address.
- `mem_rd`  out  1: read strobe, one cycle; `mem_rdata` valid the following cycle.
- `mem_rdata`  in  8: read data.
- `mem_wr`  out  1: write strobe, one cycle, with `mem_addr`/`mem_wdata`.
- `mem_wdata`  out  8: write data.

## Operation
- `spi_cs_n`, `spi_sck` and `spi_din` pass through 2-flop synchronizers; SCK rise/fall detected from synced history; `spi_din` sampled on detected rise.
- All phases quad, high nibble first. Command: 2 SCK; address: 6 SCK, MSB nibble first.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
- IDLE -> CMD on synced CS fall. CMD -> ADDR after 2 nibbles if cmd is 0xEB or 0x38, else IGNORE.
- ADDR -> DUMMY (0xEB) or WDATA (0x38) after 6 nibbles; `mem_addr` loaded.
- DUMMY: `mem_rd` pulsed once on entry; captured byte held in shift register; after `DUMMY` rises, state RDATA.
- RDATA: on each SCK fall drive next nibble; `spi_oe`=4'hF. After high nibble driven, `mem_addr`+1 and `mem_rd` pulsed to prefetch; low nibble drive followed by load of prefetched byte. Streams until CS rises.
- WDATA: two sampled nibbles form a byte; on the second, `mem_wr` pulses with current `mem_addr`, then `mem_addr`+1.
- Address increments wrap modulo 2^PA.
- IGNORE: outputs idle, wait for CS rise.
- Synced CS rise in any state -> IDLE next cycle: `spi_oe`=0, partial write byte discarded, no further strobes, an in-flight prefetch result dropped.
- `mem_rd` and `mem_wr` never both high.

## Timing
- Reset values: state IDLE, `spi_oe`=0, `spi_dout`=0, `mem_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0.
- SCK high and low phases each >= 4 `clk`, i.e. f_sck <= f_clk/8.
- CS deassert time >= 4 `clk`.
- Edge detect latency 2 `clk` after pin edge; output updated 3 `clk` after SCK fall.
- First data nibble driven on the SCK fall that ends the last dummy cycle; `spi_oe` asserts in that same `clk` cycle.
- `mem_rd` to use: data latched 1 `clk` after strobe, always before next SCK fall given the SCK limit.
- `mem_wr` pulse 1 `clk` after detected rise carrying the low nibble.
- Reset mid-transaction aborts exactly as CS rise; the master must re-assert CS.

## Structure
- Package `qspi_pkg`: command constants `QSPI_CMD_QREAD`=8'hEB, `QSPI_CMD_QWRITE`=8'h38, state enum, address-phase nibble count (6). Package shared with the master's bench.
- One sub-module `qspi_edge_sync`: 2-flop sync for CS/SCK plus rise/fall pulse outputs, used once per async input group.

## Test plan
- Reset mid-RDATA (assert `reset` 1 cycle) -> next cycle `spi_oe`=0, state IDLE, no `mem_rd`.
- Read 0xEB addr 0x000010, memory 0x10..0x13 = A5 3C 00 FF -> nibbles A,5,3,C,0,0,F,F; `mem_rd` addresses 0x10..0x13 (plus a prefetch of 0x14); `spi_oe` high only after 4th dummy fall.
- Write 0x38 addr 0x800004, data 12 34 56 78 -> four `mem_wr` pulses, addr 0x800004..7, data 12,34,56,78.
- Write 3 nibbles then CS rise -> exactly one `mem_wr` (first byte); no write for partial byte.
- Read at 0xFFFFFF for 2 bytes -> second access at 0x000000.
- Command 0x9F, then 10 SCK clocks -> no `mem_rd`/`mem_wr`, `spi_oe` stays 0; next CS cycle with 0xEB works normally.
